// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: HD44780 8-bit write-only driver. Runs the power-on init
// sequence, then accepts one command/data byte per valid/ready handshake and
// emits a millisecond-paced enable strobe for it. Each byte occupies a
// four-tick slot: SETUP, E_HIGH, then two HOLD ticks for the LCD to execute it.
module lcd_byte_writer #(
  parameter int unsigned CNT1MS      = 100000,
  parameter int unsigned PWR_WAIT_MS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int unsigned TICK_W    = $clog2(CNT1MS);
  localparam int unsigned PWR_LAST  = (PWR_WAIT_MS > 0) ? PWR_WAIT_MS - 1 : 0;
  localparam int unsigned MS_MAX    = (PWR_LAST > 1) ? PWR_LAST : 1;
  localparam int unsigned MS_W      = $clog2(MS_MAX + 1);
  localparam int unsigned HOLD_LAST = 1;
  localparam int unsigned INIT_LEN  = 4;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_SETUP,
    S_E_HIGH,
    S_HOLD,
    S_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;
  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic [1:0]        init_idx_q, init_idx_d;
  logic              init_done_d;
  logic [7:0]        data_d;
  logic              rs_d;
  logic              accept;

  // Power-on command sequence: function set, entry mode, display on, clear.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h06;
      2'd2:    init_byte = 8'h0C;
      default: init_byte = 8'h01;
    endcase
  endfunction

  assign lcd_rw = 1'b0;
  assign tick   = (tick_cnt_q == TICK_W'(CNT1MS - 1));
  assign accept = wr_valid & wr_ready;

  // Free-running 1 ms tick counter, wraps after CNT1MS cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // Next-state and next-output logic for the slot sequencer.
  always_comb begin
    state_d     = state_q;
    ms_cnt_d    = ms_cnt_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done;
    data_d      = lcd_data;
    rs_d        = lcd_rs;

    case (state_q)
      S_PWR_WAIT: begin
        if (tick) begin
          if (ms_cnt_q == MS_W'(PWR_LAST)) begin
            state_d    = S_SETUP;
            ms_cnt_d   = '0;
            init_idx_d = 2'd0;
            data_d     = init_byte(2'd0);
            rs_d       = 1'b0;
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end

      S_SETUP: begin
        if (tick) begin
          state_d = S_E_HIGH;
        end
      end

      S_E_HIGH: begin
        if (tick) begin
          state_d  = S_HOLD;
          ms_cnt_d = '0;
        end
      end

      S_HOLD: begin
        if (tick) begin
          if (ms_cnt_q == MS_W'(HOLD_LAST)) begin
            ms_cnt_d = '0;
            if (!init_done && (init_idx_q != 2'(INIT_LEN - 1))) begin
              // Chain straight into the next init command.
              state_d    = S_SETUP;
              init_idx_d = init_idx_q + 2'd1;
              data_d     = init_byte(init_idx_q + 2'd1);
              rs_d       = 1'b0;
            end else begin
              state_d     = S_IDLE;
              init_done_d = 1'b1;
            end
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end

      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          data_d  = wr_data;
          rs_d    = wr_rs;
        end
      end

      default: begin
        state_d  = S_PWR_WAIT;
        ms_cnt_d = '0;
      end
    endcase
  end

  // State and registered LCD/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_PWR_WAIT;
      ms_cnt_q   <= '0;
      init_idx_q <= '0;
      init_done  <= 1'b0;
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      wr_ready   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_cnt_q   <= ms_cnt_d;
      init_idx_q <= init_idx_d;
      init_done  <= init_done_d;
      lcd_data   <= data_d;
      lcd_rs     <= rs_d;
      lcd_e      <= (state_d == S_E_HIGH);
      wr_ready   <= (state_d == S_IDLE);
    end
  end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: slot-based reference model checked every cycle,
// plus directed init, latency table, streaming and mid-operation reset tests.
module tb_lcd_byte_writer;

  localparam int CNT = 4;
  localparam int PWR = 20;
  localparam int INIT_END = (PWR + 16) * CNT;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       init_done;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  lcd_byte_writer #(.CNT1MS(CNT), .PWR_WAIT_MS(PWR)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_rs(wr_rs),
    .wr_data(wr_data), .wr_ready(wr_ready), .init_done(init_done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int          cyc_abs = 0;

  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: list of byte slots ----------------
  typedef struct {
    int         start;
    logic       rs;
    logic [7:0] data;
  } slot_t;

  logic [7:0] rom [4];
  slot_t      slots[$];
  int         cyc;
  int         ready_at;
  logic       reset_prev = 1'b0;
  logic       armed = 1'b0;
  logic       e_exp, rs_exp, ready_exp, done_exp;
  logic [7:0] d_exp;

  initial begin
    rom[0] = 8'h38; rom[1] = 8'h06; rom[2] = 8'h0C; rom[3] = 8'h01;
  end

  function automatic int next_tick(input int c);
    int t;
    t = c;
    for (int k = 0; k < CNT; k++) if ((t % CNT) != CNT - 1) t++;
    return t;
  endfunction

  // A slot that starts at s shows lcd_e from the cycle after its first tick.
  function automatic int rise_of(input int s);
    return next_tick(s) + 1;
  endfunction

  task automatic model_reset();
    int s;
    slot_t sl;
    slots.delete();
    s = PWR * CNT;
    for (int k = 0; k < 4; k++) begin
      sl.start = s; sl.rs = 1'b0; sl.data = rom[k];
      slots.push_back(sl);
      s = rise_of(s) + 3 * CNT;
    end
    ready_at = s;
  endtask

  // Per-cycle compare of every output against the slot model.
  always @(negedge clk) begin
    slot_t sl;
    if (reset_prev) begin
      armed = 1'b1;
      cyc = 0;
      model_reset();
    end else begin
      cyc++;
    end
    if (armed) begin
      e_exp = 1'b0; d_exp = 8'h00; rs_exp = 1'b0;
      foreach (slots[i]) begin
        if (slots[i].start <= cyc) begin
          d_exp  = slots[i].data;
          rs_exp = slots[i].rs;
        end
        if (cyc >= rise_of(slots[i].start) && cyc < rise_of(slots[i].start) + CNT) e_exp = 1'b1;
      end
      ready_exp = (cyc >= ready_at);
      done_exp  = (cyc >= INIT_END);
      check("m_lcd_e",     32'(lcd_e),     32'(e_exp));
      check("m_lcd_data",  32'(lcd_data),  32'(d_exp));
      check("m_lcd_rs",    32'(lcd_rs),    32'(rs_exp));
      check("m_wr_ready",  32'(wr_ready),  32'(ready_exp));
      check("m_init_done", 32'(init_done), 32'(done_exp));
      check("m_lcd_rw",    32'(lcd_rw),    32'(1'b0));
      if (reset !== 1'b1 && wr_valid === 1'b1 && ready_exp) begin
        sl.start = cyc + 1; sl.rs = wr_rs; sl.data = wr_data;
        slots.push_back(sl);
        ready_at = rise_of(sl.start) + 3 * CNT;
      end
    end
    reset_prev = reset;
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_lcd_e"},     32'(lcd_e),     32'(1'b0));
    check({tag, "_lcd_data"},  32'(lcd_data),  32'(8'h00));
    check({tag, "_lcd_rs"},    32'(lcd_rs),    32'(1'b0));
    check({tag, "_wr_ready"},  32'(wr_ready),  32'(1'b0));
    check({tag, "_init_done"}, 32'(init_done), 32'(1'b0));
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 200 && wr_ready !== 1'b1; k++) step();
    check("ready_wait", 32'(wr_ready), 32'(1'b1));
  endtask

  // Hold the byte with wr_valid high until it is taken; acc = accept cycle.
  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    wr_rs = rs; wr_data = d; wr_valid = 1'b1;
    for (int k = 0; k < 200 && wr_ready !== 1'b1; k++) step();
    check("send_ready", 32'(wr_ready), 32'(1'b1));
    acc = cyc_abs;
    step();
  endtask

  task automatic init_check();
    int   c0, npulse;
    logic prev_e;
    c0 = cyc_abs; npulse = 0; prev_e = 1'b0;
    for (int k = 0; k < 400 && init_done !== 1'b1; k++) begin
      if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
        if (npulse < 4) check("init_byte", 32'(lcd_data), 32'(rom[npulse]));
        check("init_rs", 32'(lcd_rs), 32'(1'b0));
        npulse++;
      end
      prev_e = lcd_e;
      step();
    end
    check("init_pulses", 32'(npulse), 32'(4));
    check("init_done_cycle", 32'(cyc_abs - c0), 32'(INIT_END));
    check("init_ready", 32'(wr_ready), 32'(1'b1));
  endtask

  // ---------------- latency table ----------------
  typedef struct {
    int         delay;
    logic       rs;
    logic [7:0] data;
    int         exp_lat;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  int   acc, prev_acc, w;

  initial begin
    vecs[0] = '{delay: 0, rs: 1'b0, data: 8'h80, exp_lat: 4};
    vecs[1] = '{delay: 0, rs: 1'b1, data: 8'h47, exp_lat: 4};
    vecs[2] = '{delay: 1, rs: 1'b1, data: 8'h41, exp_lat: 3};
    vecs[3] = '{delay: 2, rs: 1'b1, data: 8'h42, exp_lat: 2};
    vecs[4] = '{delay: 3, rs: 1'b1, data: 8'h43, exp_lat: 5};
    vecs[5] = '{delay: 5, rs: 1'b0, data: 8'hC0, exp_lat: 3};
    vecs[6] = '{delay: 6, rs: 1'b1, data: 8'h31, exp_lat: 2};
    vecs[7] = '{delay: 7, rs: 1'b1, data: 8'h32, exp_lat: 5};

    reset = 1'b1; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
    repeat (3) step();
    check_reset_values("por");
    reset = 1'b0;
    init_check();

    // Latency from acceptance to lcd_e rise depends on the tick phase.
    for (int i = 0; i < NV; i++) begin
      wait_ready();
      repeat (vecs[i].delay) step();
      send(vecs[i].rs, vecs[i].data, acc);
      wr_valid = 1'b0;
      for (int k = 0; k < 40 && lcd_e !== 1'b1; k++) step();
      check("vec_latency", 32'(cyc_abs - acc), 32'(vecs[i].exp_lat));
      check("vec_data", 32'(lcd_data), 32'(vecs[i].data));
      check("vec_rs", 32'(lcd_rs), 32'(vecs[i].rs));
      w = 0;
      while (lcd_e === 1'b1 && w < 40) begin w++; step(); end
      check("vec_width", 32'(w), 32'(CNT));
    end

    // Streaming: wr_valid held high, one byte per 4 ticks.
    wait_ready();
    prev_acc = 0;
    for (int i = 0; i < 17; i++) begin
      send(i == 0 ? 1'b0 : 1'b1, i == 0 ? 8'h80 : 8'(8'h40 + i), acc);
      if (i > 0) check("stream_pitch", 32'(acc - prev_acc), 32'(4 * CNT));
      prev_acc = acc;
    end
    wr_valid = 1'b0;

    // Reset while lcd_e is high; init must rerun from scratch.
    wait_ready();
    send(1'b1, 8'h5A, acc);
    wr_valid = 1'b0;
    for (int k = 0; k < 40 && lcd_e !== 1'b1; k++) step();
    check("midrst_e_seen", 32'(lcd_e), 32'(1'b1));
    reset = 1'b1;
    step();
    check_reset_values("midrst");
    check("midrst_lcd_rw", 32'(lcd_rw), 32'(1'b0));
    step();
    step();
    reset = 1'b0;
    init_check();

    // Random traffic, including wr_valid toggling while busy and rare resets.
    for (int i = 0; i < 1500; i++) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_rs    = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom_range(0, 255));
      reset    = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    wr_valid = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
